// File: rtl/sprite_pkg.sv
// sprite_pkg: definitions shared by the sprite commit scheduler and its FIFO.
//   - sprite config register addresses on the TinyQV peripheral bus
//   - display timing line counts (vblank starts at V_ACTIVE)
//   - scheduler FSM state encoding
//   - cfg_wr_t, the queued config write (address + data)
package sprite_pkg;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_SPR0_XY   = 6'h04;
  localparam logic [5:0] ADDR_SPR0_BMP0 = 6'h06;
  localparam logic [5:0] ADDR_SPR0_BMP1 = 6'h08;
  localparam logic [5:0] ADDR_SPR0_BMP2 = 6'h0A;
  localparam logic [5:0] ADDR_SPR0_BMP3 = 6'h0C;
  localparam logic [5:0] ADDR_SPR1_XY   = 6'h0E;
  localparam logic [5:0] ADDR_SPR1_BMP0 = 6'h10;
  localparam logic [5:0] ADDR_SPR1_BMP1 = 6'h12;
  localparam logic [5:0] ADDR_SPR1_BMP2 = 6'h14;
  localparam logic [5:0] ADDR_SPR1_BMP3 = 6'h16;

  localparam int V_ACTIVE = 768;
  localparam int V_TOTAL  = 806;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2,
    WAIT  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } cfg_wr_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// sprite_cmd_fifo: synchronous FIFO holding queued sprite config writes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (ignored when full)
//   pop, pop_data   remove the head entry (ignored when empty); pop_data
//                   always shows the current head
//   level           registered occupancy
//   full, empty     decoded from level, not from the pointers
module sprite_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // pointers are exactly log2(DEPTH) wide, so they wrap on their own
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sprite_commit_sched.sv
// sprite_commit_sched: queues CPU writes to the sprite config registers and
// replays them onto the config bus only where they cannot tear the picture.
// With streaming off, writes pass straight through (one per cycle); with
// streaming on, they are held until vertical blank and drained there, at
// most BUDGET per window and at most one window per frame.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_valid/wr_addr/wr_data  CPU config write (never stalled)
//   wr_ready                  queue not full (status only)
//   stream_en, vblank         timing generator running / in vertical blank
//   cfg_we/cfg_addr/cfg_data  registered write to the sprite register file
//   fifo_level                queue occupancy
//   overflow, clr_overflow    sticky dropped-write flag and its clear
//   commit_done               pulse when a vblank window emptied the queue
//
// state | meaning
// IDLE  | nothing to pass through, waiting for vblank rise (streaming)
// PASS  | streaming off, emitting queued writes one per cycle
// DRAIN | inside a vblank window, emitting queued writes within budget
// WAIT  | window finished, holding until vblank ends
module sprite_commit_sched
  import sprite_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BUDGET = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [5:0]             wr_addr,
  input  logic [15:0]            wr_data,
  output logic                   wr_ready,
  input  logic                   stream_en,
  input  logic                   vblank,
  output logic                   cfg_we,
  output logic [5:0]             cfg_addr,
  output logic [15:0]            cfg_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic                   commit_done
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BUDGET + 1);
  localparam logic [BW-1:0] BUDGET_L = BW'(BUDGET);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_PASS  = PASS;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]    state, state_d;
  logic [BW-1:0] budget, budget_d;
  logic          done_d;
  logic          vblank_q;
  logic          vblank_rise;

  logic          fifo_full, fifo_empty;
  logic          push_ok, drop;
  logic          pass_pop, drain_pop, pop;
  logic          drain_last;
  cfg_wr_t       push_entry;
  cfg_wr_t       head;

  assign vblank_rise = vblank && !vblank_q;

  // fullness comes from the registered level, so a pop in the same cycle
  // never makes room for this cycle's push
  assign push_ok    = wr_valid && !fifo_full;
  assign drop       = wr_valid && fifo_full;
  assign wr_ready   = !fifo_full;
  assign push_entry = '{addr: wr_addr, data: wr_data};

  // IDLE also pops so a passthrough write reaches cfg_we two cycles after
  // it was pushed instead of waiting for the PASS state first
  assign pass_pop  = ((state == S_IDLE) || (state == S_PASS)) && !stream_en && !fifo_empty;
  assign drain_pop = (state == S_DRAIN) && stream_en && vblank && !fifo_empty &&
                     (budget < BUDGET_L);
  assign pop       = pass_pop || drain_pop;

  // the queue only ends up empty if no new write lands alongside the last pop
  assign drain_last = drain_pop && (fifo_level == LW'(1)) && !push_ok;

  sprite_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cfg_wr_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state;
    budget_d = budget;
    done_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!stream_en && !fifo_empty) begin
          state_d = S_PASS;
        end else if (stream_en && vblank_rise) begin
          state_d  = S_DRAIN;
          budget_d = '0;
        end
      end
      S_PASS: begin
        if (stream_en || fifo_empty) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (!stream_en) begin
          state_d = S_PASS;
        end else if (fifo_empty) begin
          state_d = S_WAIT;
          done_d  = 1'b1;
        end else if (!vblank || (budget >= BUDGET_L)) begin
          // window cut short; leftovers wait for the next frame
          state_d = S_WAIT;
        end else begin
          budget_d = budget + BW'(1);
          if (drain_last) begin
            state_d = S_WAIT;
            done_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!vblank) state_d = stream_en ? S_IDLE : S_PASS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      budget      <= '0;
      vblank_q    <= 1'b0;
      commit_done <= 1'b0;
      cfg_we      <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_d;
      budget      <= budget_d;
      vblank_q    <= vblank;
      commit_done <= done_d;
      cfg_we      <= pop;
      if (pop) begin
        cfg_addr <= head.addr;
        cfg_data <= head.data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
